// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA video-RAM arbiter.
// Grant/tag encoding and host-read handshake states.
package vga_pkg;

  localparam int SLOT_PERIOD_SVGA = 6;
  localparam int VRAM_ADDR_W      = 16;
  localparam int VRAM_DATA_W      = 16;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    HREAD = 2'd3
  } grant_e;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_PEND   = 2'd1,
    RD_FLIGHT = 2'd2
  } rd_state_e;

  function automatic logic is_read(grant_e g);
    return (g == FETCH) || (g == HREAD);
  endfunction

endpackage

// File: rtl/vga_wr_fifo.sv
// Host write FIFO holding {addr,data} pairs.
// Head entry is presented combinationally; pop advances it.
module vga_wr_fifo #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW+DW-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;
  logic [AW+DW-1:0] w_head;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign w_head  = r_mem[r_rd_ptr];
  assign o_addr  = w_head[AW+DW-1:DW];
  assign o_data  = w_head[DW-1:0];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_addr, i_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= nxt(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= nxt(r_rd_ptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Time-sliced video RAM scheduler: one fetch slot per pixel
// period, remaining slots for buffered host writes and reads.
module vga_vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W      = VRAM_ADDR_W,
  parameter int DATA_W      = VRAM_DATA_W,
  parameter int SLOT_PERIOD = SLOT_PERIOD_SVGA,
  parameter int FETCH_SLOT  = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              o_pix_ce,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_valid,
  output logic [DATA_W-1:0] o_fetch_data,
  input  logic              i_host_wr,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_full,
  output logic              o_host_ovf,
  input  logic              i_host_rd,
  input  logic [ADDR_W-1:0] i_host_rd_addr,
  output logic              o_host_rd_busy,
  output logic              o_host_rd_valid,
  output logic [DATA_W-1:0] o_host_rd_data,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_we,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int SW = (SLOT_PERIOD > 2) ? $clog2(SLOT_PERIOD) : 1;

  logic [SW-1:0]     r_slot;
  logic              r_pix_ce;
  grant_e            w_grant;
  grant_e            r_tag1;
  grant_e            r_tag2;
  rd_state_e         r_rd_state;
  rd_state_e         w_rd_nxt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_ram_we;
  logic              r_fetch_valid;
  logic [DATA_W-1:0] r_fetch_data;
  logic              r_hrd_valid;
  logic [DATA_W-1:0] r_hrd_data;
  logic              r_ovf;
  logic              w_fetch_slot;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;

  assign w_fetch_slot = (r_slot == SW'(FETCH_SLOT));
  assign w_push       = i_host_wr && !w_full;
  assign w_pop        = (w_grant == WRITE);

  vga_wr_fifo #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_addr  (i_host_addr),
    .i_data  (i_host_wdata),
    .i_pop   (w_pop),
    .o_addr  (w_head_addr),
    .o_data  (w_head_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot   <= '0;
      r_pix_ce <= 1'b0;
    end else begin
      r_pix_ce <= (r_slot == SW'(SLOT_PERIOD - 1));
      if (r_slot == SW'(SLOT_PERIOD - 1)) r_slot <= '0;
      else                                r_slot <= r_slot + 1'b1;
    end
  end

  // Reads wait behind the FIFO so they see all earlier writes.
  always_comb begin
    w_grant = NONE;
    if (w_fetch_slot && i_fetch_req)  w_grant = FETCH;
    else if (!w_empty)                w_grant = WRITE;
    else if (r_rd_state == RD_PEND)   w_grant = HREAD;
  end

  always_comb begin
    w_rd_nxt = r_rd_state;
    unique case (r_rd_state)
      RD_IDLE:   if (i_host_rd)         w_rd_nxt = RD_PEND;
      RD_PEND:   if (w_grant == HREAD)  w_rd_nxt = RD_FLIGHT;
      RD_FLIGHT: if (r_tag2 == HREAD)   w_rd_nxt = RD_IDLE;
      default:                          w_rd_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state <= RD_IDLE;
      r_rd_addr  <= '0;
    end else begin
      r_rd_state <= w_rd_nxt;
      if (r_rd_state == RD_IDLE && i_host_rd)
        r_rd_addr <= i_host_rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
    end else begin
      unique case (w_grant)
        FETCH: begin
          r_ram_addr <= i_fetch_addr;
          r_ram_we   <= 1'b0;
        end
        WRITE: begin
          r_ram_addr  <= w_head_addr;
          r_ram_wdata <= w_head_data;
          r_ram_we    <= 1'b1;
        end
        HREAD: begin
          r_ram_addr <= r_rd_addr;
          r_ram_we   <= 1'b0;
        end
        default: r_ram_we <= 1'b0;
      endcase
    end
  end

  // Tag travels alongside the RAM access to steer returned data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag1 <= NONE;
      r_tag2 <= NONE;
    end else begin
      r_tag1 <= is_read(w_grant) ? w_grant : NONE;
      r_tag2 <= r_tag1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_valid <= 1'b0;
      r_fetch_data  <= '0;
      r_hrd_valid   <= 1'b0;
      r_hrd_data    <= '0;
    end else begin
      r_fetch_valid <= (r_tag2 == FETCH);
      r_hrd_valid   <= (r_tag2 == HREAD);
      if (r_tag2 == FETCH) r_fetch_data <= i_ram_rdata;
      if (r_tag2 == HREAD) r_hrd_data   <= i_ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_ovf <= 1'b0;
    else if (i_host_wr && w_full) r_ovf <= 1'b1;
  end

  assign o_pix_ce        = r_pix_ce;
  assign o_fetch_valid   = r_fetch_valid;
  assign o_fetch_data    = r_fetch_data;
  assign o_host_full     = w_full;
  assign o_host_ovf      = r_ovf;
  assign o_host_rd_busy  = (r_rd_state != RD_IDLE);
  assign o_host_rd_valid = r_hrd_valid;
  assign o_host_rd_data  = r_hrd_data;
  assign o_ram_addr      = r_ram_addr;
  assign o_ram_wdata     = r_ram_wdata;
  assign o_ram_we        = r_ram_we;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: cycle-indexed event model
// with a synchronous RAM behind the DUT.
module tb_vga_vram_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int P  = 6;
  localparam int FS = 1;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_ce;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          host_wr = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_full;
  logic          host_ovf;
  logic          host_rd = 1'b0;
  logic [AW-1:0] host_rd_addr = '0;
  logic          host_rd_busy;
  logic          host_rd_valid;
  logic [DW-1:0] host_rd_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  vga_vram_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .SLOT_PERIOD (P),
    .FETCH_SLOT  (FS),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .o_pix_ce        (pix_ce),
    .i_fetch_req     (fetch_req),
    .i_fetch_addr    (fetch_addr),
    .o_fetch_valid   (fetch_valid),
    .o_fetch_data    (fetch_data),
    .i_host_wr       (host_wr),
    .i_host_addr     (host_addr),
    .i_host_wdata    (host_wdata),
    .o_host_full     (host_full),
    .o_host_ovf      (host_ovf),
    .i_host_rd       (host_rd),
    .i_host_rd_addr  (host_rd_addr),
    .o_host_rd_busy  (host_rd_busy),
    .o_host_rd_valid (host_rd_valid),
    .o_host_rd_data  (host_rd_data),
    .o_ram_addr      (ram_addr),
    .o_ram_wdata     (ram_wdata),
    .o_ram_we        (ram_we),
    .i_ram_rdata     (ram_rdata)
  );

  // Synchronous single-port RAM, read-before-write.
  bit   [DW-1:0] ram [65536];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [DW-1:0] pl_d = '0;

  always @(posedge clk) begin
    if (pl_en)       ram[pl_a] <= pl_d;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  typedef struct {
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } op_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  op_t           issue [int];
  logic [DW-1:0] fret  [int];
  logic [DW-1:0] hret  [int];
  logic [DW-1:0] mm    [int];
  wr_t           wq    [$];

  int            c;
  int            rd_acc;
  int            rd_ret;
  int            ovf_c;
  bit            rd_pend;
  logic [AW-1:0] rd_a;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_hd;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_fv;
  int            n_hv;
  int            n_we;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)",
             tag, obs, exp, c);
    end
  endtask

  function automatic logic [DW-1:0] mm_rd(input logic [AW-1:0] a);
    return mm.exists(int'(a)) ? mm[int'(a)] : '0;
  endfunction

  function automatic bit busy_m(input int cc);
    return rd_acc >= 0 && cc > rd_acc && (rd_ret < 0 || cc < rd_ret);
  endfunction

  task automatic model_clear();
    issue.delete();
    fret.delete();
    hret.delete();
    wq.delete();
    rd_acc    = -1;
    rd_ret    = -1;
    rd_pend   = 1'b0;
    ovf_c     = -1;
    last_addr = '0;
    c         = 0;
  endtask

  task automatic check_cycle();
    bit            we_e;
    bit            pix_e;
    pix_e = (c > 0) && (c % P == 0);
    chk("pix_ce", pix_ce, pix_e);
    we_e = 1'b0;
    if (issue.exists(c)) begin
      we_e      = issue[c].we;
      last_addr = issue[c].a;
      if (we_e) chk("ram_wdata", ram_wdata, issue[c].d);
      issue.delete(c);
    end
    chk("ram_we", ram_we, we_e);
    chk("ram_addr", ram_addr, last_addr);
    if (ram_we === 1'b1) n_we++;
    chk("fetch_valid", fetch_valid, fret.exists(c));
    if (fret.exists(c)) begin
      chk("fetch_data", fetch_data, fret[c]);
      n_fv++;
      fret.delete(c);
    end
    chk("host_rd_valid", host_rd_valid, hret.exists(c));
    if (hret.exists(c)) begin
      chk("host_rd_data", host_rd_data, hret[c]);
      last_hd = host_rd_data;
      n_hv++;
      hret.delete(c);
    end
    chk("host_rd_busy", host_rd_busy, busy_m(c));
    if (c == rd_ret) begin
      rd_acc = -1;
      rd_ret = -1;
    end
    chk("host_full", host_full, wq.size() == D);
    chk("host_ovf", host_ovf, ovf_c >= 0 && c >= ovf_c);
  endtask

  // Slot = cycles since release mod P; issue at +1, data at +3.
  task automatic model_cycle();
    bit  full0;
    wr_t e;
    full0 = (wq.size() == D);
    if ((c % P) == FS && fetch_req) begin
      issue[c+1] = '{we: 1'b0, a: fetch_addr, d: '0};
      fret[c+3]  = mm_rd(fetch_addr);
    end else if (wq.size() > 0) begin
      e = wq.pop_front();
      issue[c+1] = '{we: 1'b1, a: e.a, d: e.d};
      mm[int'(e.a)] = e.d;
    end else if (rd_pend) begin
      issue[c+1] = '{we: 1'b0, a: rd_a, d: '0};
      hret[c+3]  = mm_rd(rd_a);
      rd_ret     = c + 3;
      rd_pend    = 1'b0;
    end
    if (host_wr) begin
      if (!full0) wq.push_back('{a: host_addr, d: host_wdata});
      else if (ovf_c < 0) ovf_c = c + 1;
    end
    if (host_rd && !busy_m(c)) begin
      rd_acc  = c;
      rd_pend = 1'b1;
      rd_a    = host_rd_addr;
    end
  endtask

  task automatic step();
    check_cycle();
    model_cycle();
    @(posedge clk);
    c++;
    @(negedge clk);
  endtask

  task automatic idle_in();
    fetch_req = 1'b0;
    host_wr   = 1'b0;
    host_rd   = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
    mm[int'(a)] = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_in();
    #1;
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_pix_ce", pix_ce, 1'b0);
    chk("rst_fetch_valid", fetch_valid, 1'b0);
    chk("rst_busy", host_rd_busy, 1'b0);
    chk("rst_ovf", host_ovf, 1'b0);
    chk("rst_full", host_full, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    n_fv = 0;
    n_hv = 0;
    n_we = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_clear();
    @(negedge clk);
    preload(16'h0123, 16'hBEEF);
    for (int i = 0; i < 8; i++)
      preload(AW'(i * 8), DW'($urandom));
    do_reset();

    // Idle after release: only pix_ce toggles.
    repeat (20) step();
    chk("idle_we_cnt", n_we, 0);

    // Display fetch alone, fixed address.
    n_fv       = 0;
    fetch_req  = 1'b1;
    fetch_addr = 16'h0123;
    repeat (24) step();
    chk("fetch_cnt", n_fv, 3);

    // Write burst against active fetch; FIFO grows once per period.
    for (int i = 0; i < 36; i++) begin
      host_wr    = 1'b1;
      host_addr  = AW'(16'h0010 + i);
      host_wdata = DW'(16'hA000 + i);
      step();
    end
    host_wr = 1'b0;
    chk("ovf_after_burst", host_ovf, 1'b1);
    idle_in();
    repeat (10) step();

    // Write then read same word; a second read while busy is ignored.
    n_hv       = 0;
    host_wr    = 1'b1;
    host_addr  = 16'h0040;
    host_wdata = 16'h1234;
    step();
    host_wr      = 1'b0;
    host_rd      = 1'b1;
    host_rd_addr = 16'h0040;
    step();
    host_rd_addr = 16'h0010;
    repeat (2) step();
    host_rd = 1'b0;
    repeat (12) step();
    chk("hrd_cnt", n_hv, 1);
    chk("hrd_data", last_hd, 16'h1234);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      fetch_req    = 1'($urandom_range(0, 1));
      fetch_addr   = AW'($urandom_range(0, 63));
      host_wr      = ($urandom_range(0, 2) == 0);
      host_addr    = AW'($urandom_range(0, 63));
      host_wdata   = DW'($urandom);
      host_rd      = ($urandom_range(0, 3) == 0);
      host_rd_addr = AW'($urandom_range(0, 63));
      step();
    end
    idle_in();
    repeat (16) step();

    // Reset one clock after a fetch grant.
    fetch_req  = 1'b1;
    fetch_addr = 16'h0123;
    for (int i = 0; i < P && (c % P) != FS; i++) step();
    step();
    do_reset();
    repeat (20) step();
    chk("post_rst_fv", n_fv, 0);
    chk("post_rst_we", n_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
